uart_cmd_ctrl: RTL and testbench

Command controller between the UART receiver/transmitter pair and the delay-line configuration registers. It parses one- and two-byte commands arriving from `uart_rx` and performs register reads or writes on a simple synchronous register bus. It sequences `uart_tx` to return one response byte per command. It sits in the top level in place of the raw loopback, turning the serial link into the host configuration path.

---
 rtl/uart_cmd_ctrl_if.sv | 25 ++
 rtl/uart_cmd_ctrl.sv | 119 +++++++++++
 tb/tb_uart_cmd_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// rtl/uart_cmd_ctrl_if.sv - UART byte stream and register bus seen by the command controller
interface uart_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  tx_ready;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic                  reg_wr_en;
  logic [DATA_WIDTH-1:0] reg_wr_data;
  logic [DATA_WIDTH-1:0] reg_rd_data;

  modport master (
    input  rx_valid, rx_data, tx_ready, reg_rd_data,
    output tx_start, tx_data, reg_addr, reg_wr_en, reg_wr_data
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, reg_rd_data,
    input  tx_start, tx_data, reg_addr, reg_wr_en, reg_wr_data
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - parses UART command bytes into register reads/writes, one response byte each
module uart_cmd_ctrl #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    TIMEOUT_CLKS = 50_000,
  parameter logic [DATA_WIDTH-1:0] ACK_BYTE     = 8'hA5,
  parameter logic [DATA_WIDTH-1:0] NAK_BYTE     = 8'hEE
) (
  input  logic             clk,
  input  logic             rst,
  uart_cmd_ctrl_if.master  bus,
  output logic             busy,
  output logic             timeout,
  output logic             overrun
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [DATA_WIDTH-1:0] LOW_MASK  = DATA_WIDTH'((1 << ADDR_WIDTH) - 1);
  // Bits between the address field and the read/write flag must be zero.
  localparam logic [DATA_WIDTH-1:0] RSVD_MASK = ~LOW_MASK & {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, WAIT_DATA, WRITE, READ, SEND} state_t;

  state_t                state_q, state_nxt;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
  logic [TW-1:0]         timer_q, timer_nxt;
  logic                  tx_start_c, wr_en_c, timeout_c, overrun_c;
  logic                  malformed;

  assign malformed = |(bus.rx_data & RSVD_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_nxt;
      tx_data_q <= tx_data_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      timer_q   <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    tx_data_nxt = tx_data_q;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    timer_nxt   = timer_q;
    tx_start_c  = 1'b0;
    wr_en_c     = 1'b0;
    timeout_c   = 1'b0;
    overrun_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          addr_nxt = bus.rx_data[ADDR_WIDTH-1:0];
          if (malformed) begin
            tx_data_nxt = NAK_BYTE;
            state_nxt   = SEND;
          end else if (bus.rx_data[DATA_WIDTH-1]) begin
            timer_nxt = '0;
            state_nxt = WAIT_DATA;
          end else begin
            state_nxt = READ;
          end
        end
      end
      WAIT_DATA: begin
        // A data byte arriving on the expiry cycle still completes the write.
        if (bus.rx_valid) begin
          wdata_nxt = bus.rx_data;
          state_nxt = WRITE;
        end else if (timer_q == TW'(TIMEOUT_CLKS - 1)) begin
          timeout_c = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer_q + TW'(1);
        end
      end
      WRITE: begin
        overrun_c   = bus.rx_valid;
        wr_en_c     = 1'b1;
        tx_data_nxt = ACK_BYTE;
        state_nxt   = SEND;
      end
      READ: begin
        overrun_c   = bus.rx_valid;
        tx_data_nxt = bus.reg_rd_data;
        state_nxt   = SEND;
      end
      SEND: begin
        overrun_c = bus.rx_valid;
        if (bus.tx_ready) begin
          tx_start_c = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are masked during reset so a pending write/response never leaks out.
  assign bus.tx_start    = tx_start_c & ~rst;
  assign bus.reg_wr_en   = wr_en_c & ~rst;
  assign bus.tx_data     = tx_data_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wr_data = wdata_q;
  assign busy            = (state_q != IDLE) & ~rst;
  assign timeout         = timeout_c & ~rst;
  assign overrun         = overrun_c & ~rst;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - table-driven bench for uart_cmd_ctrl with a 16-entry register model
module tb_uart_cmd_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic busy, timeout, overrun;
  logic model_clr;

  uart_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  uart_cmd_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CLKS(100),
    .ACK_BYTE(8'hA5), .NAK_BYTE(8'hEE)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy(busy), .timeout(timeout), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [7:0] regs [16];
  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'(8'h10 + i);
    end else if (bus.reg_wr_en) begin
      regs[bus.reg_addr] <= bus.reg_wr_data;
    end
  end
  assign bus.reg_rd_data = regs[bus.reg_addr];

  int tx_cnt = 0, wr_cnt = 0, to_cnt = 0;
  always @(negedge clk) begin
    if (bus.tx_start)  tx_cnt <= tx_cnt + 1;
    if (bus.reg_wr_en) wr_cnt <= wr_cnt + 1;
    if (timeout)       to_cnt <= to_cnt + 1;
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_tx(output int lat, output logic [7:0] txd, output int wrc,
                         output logic [3:0] wa, output logic [7:0] wd);
    lat = -1; txd = '0; wrc = 0; wa = '0; wd = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.reg_wr_en) begin
        wrc++;
        wa = bus.reg_addr;
        wd = bus.reg_wr_data;
      end
      if (bus.tx_start) begin
        lat = n;
        txd = bus.tx_data;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       two;
    logic [7:0] data;
    logic [7:0] exp_tx;
    int         exp_lat;
    int         exp_wr;
    logic [3:0] exp_addr;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, wrc, snap_tx, snap_wr, snap_to, tlat, bad;
    logic [7:0] txd, wd;
    logic [3:0] wa;

    vecs[0]  = '{8'h83, 1'b1, 8'h3C, 8'hA5, 2, 1, 4'h3};
    vecs[1]  = '{8'h03, 1'b0, 8'h00, 8'h3C, 2, 0, 4'h3};
    vecs[2]  = '{8'h43, 1'b0, 8'h00, 8'hEE, 1, 0, 4'h3};
    vecs[3]  = '{8'h8F, 1'b1, 8'h00, 8'hA5, 2, 1, 4'hF};
    vecs[4]  = '{8'h0F, 1'b0, 8'h00, 8'h00, 2, 0, 4'hF};
    vecs[5]  = '{8'h01, 1'b0, 8'h00, 8'h11, 2, 0, 4'h1};
    vecs[6]  = '{8'hF1, 1'b0, 8'h00, 8'hEE, 1, 0, 4'h1};
    vecs[7]  = '{8'h80, 1'b1, 8'hFF, 8'hA5, 2, 1, 4'h0};
    vecs[8]  = '{8'h00, 1'b0, 8'h00, 8'hFF, 2, 0, 4'h0};
    vecs[9]  = '{8'h82, 1'b1, 8'h5A, 8'hA5, 2, 1, 4'h2};
    vecs[10] = '{8'h12, 1'b0, 8'h00, 8'hEE, 1, 0, 4'h2};

    rst = 1'b1; model_clr = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_tx_start", bus.tx_start, 0);
    @(posedge clk); #1;
    rst = 1'b0; model_clr = 1'b0;
    @(negedge clk);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_reg_addr", bus.reg_addr, 0);
    check("rst_wr_data", bus.reg_wr_data, 0);
    check("rst_flags", {busy, timeout, overrun, bus.reg_wr_en}, 0);

    foreach (vecs[i]) begin
      send_byte(vecs[i].cmd);
      if (vecs[i].two) send_byte(vecs[i].data);
      wait_tx(lat, txd, wrc, wa, wd);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_tx_data", i), txd, vecs[i].exp_tx);
      check($sformatf("v%0d_wr_count", i), wrc, vecs[i].exp_wr);
      if (vecs[i].exp_wr == 1) begin
        check($sformatf("v%0d_wr_addr", i), wa, vecs[i].exp_addr);
        check($sformatf("v%0d_wr_data", i), wd, vecs[i].data);
      end
      check($sformatf("v%0d_reg_addr", i), bus.reg_addr, vecs[i].exp_addr);
      @(negedge clk);
      check($sformatf("v%0d_idle_after", i), {busy, bus.tx_start}, 0);
    end

    // Abandoned write: timeout 100 cycles after the command, nothing written or sent.
    snap_tx = tx_cnt; snap_wr = wr_cnt; tlat = -1;
    send_byte(8'h85);
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      if (timeout) begin
        tlat = n;
        check("to_busy_during", busy, 1);
        break;
      end
    end
    check("to_latency", tlat, 100);
    @(negedge clk);
    check("to_busy_after", {busy, timeout}, 0);
    check("to_no_write", wr_cnt - snap_wr, 0);
    check("to_no_tx", tx_cnt - snap_tx, 0);
    send_byte(8'h05);
    wait_tx(lat, txd, wrc, wa, wd);
    check("to_read_after", txd, 8'h15);
    check("to_read_nowr", wrc, 0);

    // Data byte on the expiry cycle: the write wins.
    snap_to = to_cnt;
    send_byte(8'h84);
    repeat (98) @(posedge clk);
    send_byte(8'h99);
    wait_tx(lat, txd, wrc, wa, wd);
    check("edge_wr_count", wrc, 1);
    check("edge_wr_data", wd, 8'h99);
    check("edge_ack", txd, 8'hA5);
    check("edge_no_timeout", to_cnt - snap_to, 0);
    send_byte(8'h04);
    wait_tx(lat, txd, wrc, wa, wd);
    check("edge_readback", txd, 8'h99);

    // Transmitter stall for 500 cycles.
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    snap_tx = tx_cnt; bad = 0;
    send_byte(8'h02);
    for (int n = 1; n <= 500; n++) begin
      @(negedge clk);
      if (bus.tx_start) bad++;
      if (n >= 2 && bus.tx_data !== 8'h5A) bad++;
    end
    check("stall_quiet", bad, 0);
    check("stall_busy", busy, 1);
    @(posedge clk); #1;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    check("stall_start", bus.tx_start, 1);
    check("stall_tx_data", bus.tx_data, 8'h5A);
    @(negedge clk);
    check("stall_single", tx_cnt - snap_tx, 1);
    check("stall_idle", busy, 0);

    // Overrun while waiting in SEND.
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    snap_wr = wr_cnt;
    send_byte(8'h03);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h81;
    @(negedge clk);
    check("ovr_pulse", {overrun, busy}, 2'b11);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("ovr_single", overrun, 0);
    @(posedge clk); #1;
    bus.tx_ready = 1'b1;
    wait_tx(lat, txd, wrc, wa, wd);
    check("ovr_response", txd, 8'h3C);
    @(negedge clk);
    check("ovr_idle", busy, 0);
    check("ovr_no_write", wr_cnt - snap_wr, 0);

    // Reset while a write is waiting for its data byte.
    snap_wr = wr_cnt;
    send_byte(8'h87);
    @(negedge clk);
    check("mrst_pending", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mrst_in_reset", {busy, bus.reg_wr_en, bus.tx_start}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_tx_data", bus.tx_data, 0);
    check("mrst_reg_addr", bus.reg_addr, 0);
    check("mrst_wr_data", bus.reg_wr_data, 0);
    check("mrst_flags", {busy, timeout, overrun, bus.tx_start}, 0);
    send_byte(8'h07);
    wait_tx(lat, txd, wrc, wa, wd);
    check("mrst_read", txd, 8'h17);
    check("mrst_read_lat", lat, 2);
    check("mrst_no_write", wr_cnt - snap_wr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
